// File: rtl/shift_reg_pkg.sv
// Shared types for the multiplier shift register slice.
// Build option: ARITH_SHIFT_EN adds sign-extending right shifts.
package shift_reg_pkg;

  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;

  typedef enum logic [1:0] {
    OP_HOLD,
    OP_LOAD,
    OP_SHIFT
  } shift_op_e;

endpackage

// File: rtl/param_shift_register_counter.sv
// Saturating shift counter; Done marks LIMIT shifts since clear.
// Build option: none (ARITH_SHIFT_EN only affects the top).
module shift_counter #(
  parameter int LIMIT = 8,
  localparam int CNT_W = $clog2(LIMIT + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] Count,
  output logic             Done
);

  logic [CNT_W-1:0] cnt_nxt;

  assign cnt_nxt = Count + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      Count <= '0;
      Done  <= 1'b0;
    end else if (inc && !Done) begin
      Count <= cnt_nxt;
      Done  <= (cnt_nxt == CNT_W'(LIMIT));
    end
  end

endmodule

// File: rtl/param_shift_register.sv
// N-bit load/shift register with serial out and shift counter.
// Build option: ARITH_SHIFT_EN adds Arith (sign-extending right shift).
module param_shift_register
  import shift_reg_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int LIMIT = WIDTH,
  localparam int CNT_W = $clog2(LIMIT + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Load,
  input  logic             Shift,
  input  logic             Dir,
  input  logic             q,
`ifdef ARITH_SHIFT_EN
  input  logic             Arith,
`endif
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             Data_Out,
  output logic [CNT_W-1:0] Count,
  output logic             Done
);

  shift_op_e op;
  logic      in_bit;

  always_comb begin
    op = OP_HOLD;
    if (Load) begin
      op = OP_LOAD;
    end else if (Shift && !Done) begin
      op = OP_SHIFT;
    end
  end

`ifdef ARITH_SHIFT_EN
  assign in_bit = (Arith && Dir == DIR_RIGHT) ? Q[WIDTH-1] : q;
`else
  assign in_bit = q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      Q        <= '0;
      Data_Out <= 1'b0;
    end else begin
      unique case (op)
        OP_LOAD: begin
          Q        <= D;
          Data_Out <= 1'b0;
        end
        OP_SHIFT: begin
          if (Dir == DIR_LEFT) begin
            Q        <= {Q[WIDTH-2:0], in_bit};
            Data_Out <= Q[WIDTH-1];
          end else begin
            Q        <= {in_bit, Q[WIDTH-1:1]};
            Data_Out <= Q[0];
          end
        end
        default: ;
      endcase
    end
  end

  shift_counter #(
    .LIMIT(LIMIT)
  ) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (op == OP_LOAD),
    .inc  (op == OP_SHIFT),
    .Count(Count),
    .Done (Done)
  );

endmodule
